// File: rtl/axis_dest_decoder.sv
// axis_dest_decoder: AXI4-Stream 1-to-N ingress router.
// The first beat's binary TDEST is decoded to a one-hot master select that is
// held until TLAST. Beats pass through one registered output stage. Packets
// sent to a nonexistent master are consumed, discarded and counted.
module axis_dest_decoder #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned DEST_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  // slave side
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tlast,
  input  logic [DEST_WIDTH-1:0]  s_tdest,
  // master side
  output logic [NUM_MASTERS-1:0] m_tvalid,
  input  logic [NUM_MASTERS-1:0] m_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tlast,
  // status
  output logic                   decode_err,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  // Packet-level state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]             state_q,      state_d;
  logic [NUM_MASTERS-1:0] route_sel_q,  route_sel_d;
  logic                   out_valid_q,  out_valid_d;
  logic [NUM_MASTERS-1:0] out_sel_q,    out_sel_d;
  logic [DATA_WIDTH-1:0]  out_data_q,   out_data_d;
  logic                   out_last_q,   out_last_d;
  logic                   decode_err_q, decode_err_d;
  logic [CNT_WIDTH-1:0]   drop_count_q, drop_count_d;

  logic                   dest_ok;
  logic [NUM_MASTERS-1:0] dest_onehot;
  logic                   drain;
  logic                   free;
  logic                   accept;

  // Destination range check and binary-to-one-hot decode
  assign dest_ok     = (32'(s_tdest) < NUM_MASTERS);
  assign dest_onehot = dest_ok ? ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << s_tdest) : '0;

  // Output register occupancy: a held beat leaves when its selected master is ready
  assign drain = out_valid_q & (|(out_sel_q & m_tready));
  assign free  = ~out_valid_q | drain;

  // Slave ready: discarded beats always sink, routed beats need a free register
  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      ST_IDLE:  s_tready = dest_ok ? free : 1'b1;
      ST_ROUTE: s_tready = free;
      ST_DROP:  s_tready = 1'b1;
      default:  s_tready = 1'b0;
    endcase
  end

  assign accept = s_tvalid & s_tready;

  // Next-state, output-register load/drain and drop accounting
  always_comb begin
    state_d      = state_q;
    route_sel_d  = route_sel_q;
    out_valid_d  = out_valid_q;
    out_sel_d    = out_sel_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    decode_err_d = 1'b0;
    drop_count_d = drop_count_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dest_ok) begin
            out_valid_d = 1'b1;
            out_sel_d   = dest_onehot;
            out_data_d  = s_tdata;
            out_last_d  = s_tlast;
            route_sel_d = dest_onehot;
            state_d     = s_tlast ? ST_IDLE : ST_ROUTE;
          end else begin
            decode_err_d = 1'b1;
            if (drop_count_q != '1) begin
              drop_count_d = drop_count_q + CNT_WIDTH'(1);
            end
            state_d = s_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_ROUTE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_sel_d   = route_sel_q;
          out_data_d  = s_tdata;
          out_last_d  = s_tlast;
          if (s_tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      route_sel_q  <= '0;
      out_valid_q  <= 1'b0;
      out_sel_q    <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      decode_err_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      route_sel_q  <= route_sel_d;
      out_valid_q  <= out_valid_d;
      out_sel_q    <= out_sel_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      decode_err_q <= decode_err_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_tvalid   = out_valid_q ? out_sel_q : '0;
  assign m_tdata    = out_data_q;
  assign m_tlast    = out_last_q;
  assign decode_err = decode_err_q;
  assign drop_count = drop_count_q;

  // Protocol invariants: one master at a time, held beat stays stable
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(m_tvalid));
  a_hold:   assert property (@(posedge clk) disable iff (reset)
                             (out_valid_q && !drain) |=>
                             (out_valid_q && $stable(out_sel_q) && $stable(out_data_q) && $stable(out_last_q)));

endmodule

// File: tb/tb_axis_dest_decoder.sv
// Testbench for axis_dest_decoder: two instances (4 masters / 16-bit counter and
// 3 masters / 2-bit counter) share stimulus. A packet-level scoreboard checks
// both every cycle; directed table and sequences cover the corner cases.
module tb_axis_dest_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tvalid;
  logic        s_tlast;
  logic [31:0] s_tdata;
  logic [1:0]  s_tdest;
  logic [3:0]  m_tready;

  logic        a_srdy, a_ml, a_err;
  logic [3:0]  a_mv;
  logic [31:0] a_md;
  logic [15:0] a_cnt;

  logic        b_srdy, b_ml, b_err;
  logic [2:0]  b_mv;
  logic [31:0] b_md;
  logic [1:0]  b_cnt;

  axis_dest_decoder #(.NUM_MASTERS(4), .DEST_WIDTH(2), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(a_srdy), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tdest(s_tdest),
    .m_tvalid(a_mv), .m_tready(m_tready), .m_tdata(a_md), .m_tlast(a_ml),
    .decode_err(a_err), .drop_count(a_cnt)
  );

  axis_dest_decoder #(.NUM_MASTERS(3), .DEST_WIDTH(2), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(b_srdy), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tdest(s_tdest),
    .m_tvalid(b_mv), .m_tready(m_tready[2:0]), .m_tdata(b_md), .m_tlast(b_ml),
    .decode_err(b_err), .drop_count(b_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- scoreboard (packet rules, per instance) ----------------
  typedef struct packed {
    logic [1:0]  dest;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic [3:0]  o_mv  [2];
  logic [31:0] o_md  [2];
  logic        o_ml  [2];
  logic        o_err [2];
  logic [15:0] o_cnt [2];
  logic        o_rdy [2];

  assign o_mv[0]  = a_mv;            assign o_mv[1]  = {1'b0, b_mv};
  assign o_md[0]  = a_md;            assign o_md[1]  = b_md;
  assign o_ml[0]  = a_ml;            assign o_ml[1]  = b_ml;
  assign o_err[0] = a_err;           assign o_err[1] = b_err;
  assign o_cnt[0] = a_cnt;           assign o_cnt[1] = {14'b0, b_cnt};
  assign o_rdy[0] = a_srdy;          assign o_rdy[1] = b_srdy;

  int    nm_of [2] = '{4, 3};
  int    cmax  [2] = '{65535, 3};
  int    mode  [2];   // 0: between packets, 1: forwarding, 2: discarding
  bit    have  [2];   // a beat is waiting in the output stage
  beat_t head  [2];
  logic [1:0] route [2];
  bit    exp_err [2];
  int    exp_cnt [2];

  task automatic model_cycle(input int n);
    logic [3:0] exp_mv;
    bit         fr;
    bit         exp_rdy;
    string      p;
    p = (n == 0) ? "a" : "b";
    chk({p, "_decode_err"}, 64'(o_err[n]), 64'(exp_err[n]));
    chk({p, "_drop_count"}, 64'(o_cnt[n]), 64'(exp_cnt[n]));
    if (have[n]) begin
      exp_mv = 4'b0001 << head[n].dest;
      chk({p, "_m_tvalid"}, 64'(o_mv[n]), 64'(exp_mv));
      chk({p, "_m_tdata"},  64'(o_md[n]), 64'(head[n].data));
      chk({p, "_m_tlast"},  64'(o_ml[n]), 64'(head[n].last));
    end else begin
      chk({p, "_m_tvalid_idle"}, 64'(o_mv[n]), 64'd0);
    end
    fr = !have[n] || m_tready[head[n].dest];
    if (mode[n] == 2 || (mode[n] == 0 && int'(s_tdest) >= nm_of[n])) exp_rdy = 1'b1;
    else exp_rdy = fr;
    chk({p, "_s_tready"}, 64'(o_rdy[n]), 64'(exp_rdy));
    if (have[n] && m_tready[head[n].dest]) have[n] = 1'b0;
    exp_err[n] = 1'b0;
    if (s_tvalid && exp_rdy) begin
      case (mode[n])
        0: begin
          if (int'(s_tdest) < nm_of[n]) begin
            have[n]  = 1'b1;
            head[n]  = '{dest: s_tdest, data: s_tdata, last: s_tlast};
            route[n] = s_tdest;
            mode[n]  = s_tlast ? 0 : 1;
          end else begin
            exp_err[n] = 1'b1;
            if (exp_cnt[n] < cmax[n]) exp_cnt[n]++;
            mode[n] = s_tlast ? 0 : 2;
          end
        end
        1: begin
          have[n] = 1'b1;
          head[n] = '{dest: route[n], data: s_tdata, last: s_tlast};
          if (s_tlast) mode[n] = 0;
        end
        default: if (s_tlast) mode[n] = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        mode[n] = 0; have[n] = 1'b0; exp_err[n] = 1'b0; exp_cnt[n] = 0;
      end else begin
        model_cycle(n);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic [31:0] x, input logic l);
    s_tvalid = v; s_tdest = d; s_tdata = x; s_tlast = l;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  dest;
    logic [31:0] data;
    logic        last;
    logic [3:0]  exp_mv;
    logic [31:0] exp_d;
    logic        exp_l;
  } vec_t;

  vec_t tbl[10];
  int   cnt_exp[5];

  initial begin
    // single-beat packets to each master, then a 4-beat packet whose later
    // TDEST must be ignored, then a back-to-back packet to another master
    tbl[0] = '{1'b1, 2'd0, 32'hA0, 1'b1, 4'b0001, 32'hA0, 1'b1};
    tbl[1] = '{1'b1, 2'd1, 32'hA1, 1'b1, 4'b0010, 32'hA1, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 32'hA2, 1'b1, 4'b0100, 32'hA2, 1'b1};
    tbl[3] = '{1'b1, 2'd3, 32'hA3, 1'b1, 4'b1000, 32'hA3, 1'b1};
    tbl[4] = '{1'b1, 2'd2, 32'hB0, 1'b0, 4'b0100, 32'hB0, 1'b0};
    tbl[5] = '{1'b1, 2'd1, 32'hB1, 1'b0, 4'b0100, 32'hB1, 1'b0};
    tbl[6] = '{1'b1, 2'd1, 32'hB2, 1'b0, 4'b0100, 32'hB2, 1'b0};
    tbl[7] = '{1'b1, 2'd1, 32'hB3, 1'b1, 4'b0100, 32'hB3, 1'b1};
    tbl[8] = '{1'b1, 2'd1, 32'hC0, 1'b1, 4'b0010, 32'hC0, 1'b1};
    tbl[9] = '{1'b0, 2'd0, 32'h00, 1'b0, 4'b0000, 32'h00, 1'b0};
    cnt_exp = '{1, 2, 3, 3, 3};

    reset    = 1'b1;
    m_tready = 4'hF;
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_m_tvalid", 64'(a_mv), 64'd0);
    chk("rst_a_m_tdata", 64'(a_md), 64'd0);
    chk("rst_a_m_tlast", 64'(a_ml), 64'd0);
    chk("rst_a_decode_err", 64'(a_err), 64'd0);
    chk("rst_a_drop_count", 64'(a_cnt), 64'd0);
    chk("rst_b_m_tvalid", 64'(b_mv), 64'd0);
    chk("rst_b_drop_count", 64'(b_cnt), 64'd0);
    reset = 1'b0;
    step();

    // table: routing, latency, route hold and back-to-back switch
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].dest, tbl[i].data, tbl[i].last);
      #1;
      chk("tbl_s_tready", 64'(a_srdy), 64'd1);
      step();
      chk("tbl_m_tvalid", 64'(a_mv), 64'(tbl[i].exp_mv));
      if (tbl[i].exp_mv != 4'b0000) begin
        chk("tbl_m_tdata", 64'(a_md), 64'(tbl[i].exp_d));
        chk("tbl_m_tlast", 64'(a_ml), 64'(tbl[i].exp_l));
      end
    end

    // backpressure on master 3 during a 3-beat packet
    m_tready = 4'b0111;
    drive(1'b1, 2'd3, 32'hD0, 1'b0);
    #1;
    chk("bp_s_tready_empty", 64'(a_srdy), 64'd1);
    step();
    chk("bp_m_tvalid", 64'(a_mv), 64'b1000);
    drive(1'b1, 2'd3, 32'hD1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_s_tready_full", 64'(a_srdy), 64'd0);
      step();
      chk("bp_hold_m_tvalid", 64'(a_mv), 64'b1000);
      chk("bp_hold_m_tdata", 64'(a_md), 64'hD0);
    end
    m_tready = 4'hF;
    #1;
    chk("bp_s_tready_drain", 64'(a_srdy), 64'd1);
    step();
    chk("bp_beat1_m_tdata", 64'(a_md), 64'hD1);
    drive(1'b1, 2'd3, 32'hD2, 1'b1);
    step();
    chk("bp_beat2_m_tdata", 64'(a_md), 64'hD2);
    chk("bp_beat2_m_tlast", 64'(a_ml), 64'd1);
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    step();
    chk("bp_done_m_tvalid", 64'(a_mv), 64'd0);

    // 3-master instance: dest 3 packet is discarded, then dest 0 routes
    do_reset();
    drive(1'b1, 2'd3, 32'h11, 1'b0);
    #1;
    chk("drop_s_tready_b1", 64'(b_srdy), 64'd1);
    step();
    chk("drop_err_b1", 64'(b_err), 64'd1);
    chk("drop_cnt_b1", 64'(b_cnt), 64'd1);
    chk("drop_mv_b1", 64'(b_mv), 64'd0);
    drive(1'b1, 2'd3, 32'h12, 1'b1);
    #1;
    chk("drop_s_tready_b2", 64'(b_srdy), 64'd1);
    step();
    chk("drop_err_b2", 64'(b_err), 64'd0);
    chk("drop_cnt_b2", 64'(b_cnt), 64'd1);
    chk("drop_mv_b2", 64'(b_mv), 64'd0);
    drive(1'b1, 2'd0, 32'h13, 1'b1);
    step();
    chk("after_drop_mv", 64'(b_mv), 64'b001);
    chk("after_drop_md", 64'(b_md), 64'h13);
    chk("after_drop_err", 64'(b_err), 64'd0);
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    step();

    // reset in the middle of a packet to master 1
    do_reset();
    drive(1'b1, 2'd1, 32'h21, 1'b0);
    step();
    drive(1'b1, 2'd1, 32'h22, 1'b0);
    step();
    chk("mid_pkt_m_tvalid", 64'(a_mv), 64'b0010);
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_m_tvalid", 64'(a_mv), 64'd0);
    chk("async_rst_m_tdata", 64'(a_md), 64'd0);
    chk("async_rst_m_tlast", 64'(a_ml), 64'd0);
    chk("async_rst_b_cnt", 64'(b_cnt), 64'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 2'd2, 32'hE0, 1'b0);
    step();
    chk("post_rst_m_tvalid", 64'(a_mv), 64'b0100);
    chk("post_rst_m_tdata", 64'(a_md), 64'hE0);
    drive(1'b1, 2'd1, 32'hE1, 1'b1);
    step();
    chk("post_rst_route_hold", 64'(a_mv), 64'b0100);
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    step();

    // saturating 2-bit drop counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd3, 32'(i), 1'b1);
      step();
      chk("sat_drop_count", 64'(b_cnt), 64'(cnt_exp[i]));
      chk("sat_decode_err", 64'(b_err), 64'd1);
    end
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    step();
    chk("sat_err_clear", 64'(b_err), 64'd0);
    chk("sat_hold", 64'(b_cnt), 64'd3);

    // randomized traffic checked by the scoreboard
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s_tvalid = ($urandom_range(0, 9) < 7);
      s_tdest  = 2'($urandom_range(0, 3));
      s_tdata  = $urandom;
      s_tlast  = ($urandom_range(0, 2) == 0);
      m_tready = 4'($urandom_range(0, 15));
      step();
    end
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    m_tready = 4'hF;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_dest_decoder.md
Name: axis_dest_decoder

Overview:
- AXI4-Stream 1-to-N router on the ingress side of the interconnect.
- Decodes the binary TDEST of each packet's first beat into a one-hot master select and holds that route until TLAST.
- Drives beats through a single registered output stage; the one-hot select is the inverse of the interconnect's one-hot-to-index encoding.
- Packets addressed to a nonexistent master are consumed, discarded and counted.

Parameters:
- NUM_MASTERS, 4, number of downstream master ports (>=2).
- DEST_WIDTH, 2, width of s_tdest; must satisfy 2**DEST_WIDTH >= NUM_MASTERS.
- DATA_WIDTH, 32, TDATA width in bits.
- CNT_WIDTH, 16, width of the dropped-packet counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_tvalid  input  1  slave beat valid.
- s_tready  output  1  slave beat accepted when s_tvalid & s_tready.
- s_tdata  input  DATA_WIDTH  slave data.
- s_tlast  input  1  last beat of packet.
- s_tdest  input  DEST_WIDTH  binary destination; sampled only on first beat.
- m_tvalid  output  NUM_MASTERS  per-master valid; at most one bit set.
- m_tready  input  NUM_MASTERS  per-master ready.
- m_tdata  output  DATA_WIDTH  shared data to all masters.
- m_tlast  output  1  shared last flag.
- decode_err  output  1  one-cycle pulse when a packet with out-of-range dest is accepted (first beat).
- drop_count  output  CNT_WIDTH  dropped packets, saturating.

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, out_sel=0, m_tvalid=0, m_tdata=0, m_tlast=0, decode_err=0, drop_count=0. Reset mid-packet abandons the packet and any held beat. After release, the next accepted beat is treated as a first beat.
- States:
  - IDLE: waiting for a first beat.
  - ROUTE: mid-packet, route latched in route_sel.
  - DROP: mid-packet, discarding.
- Output register:
  - out_valid, out_sel (one-hot), out_data, out_last.
  - m_tvalid[i] = out_valid & out_sel[i]; m_tdata=out_data; m_tlast=out_last.
  - drain = out_valid & |(out_sel & m_tready).
  - free = !out_valid | drain.
- s_tready:
  - IDLE with s_tdest >= NUM_MASTERS: 1.
  - DROP: 1.
  - IDLE with valid dest, and ROUTE: free.
  - Purely combinational from state, s_tdest, out regs and m_tready; never depends on s_tvalid.
- IDLE, accepted beat, dest valid:
  - sel = one-hot(s_tdest); load output register with sel, s_tdata, s_tlast.
  - route_sel=sel; next state IDLE if s_tlast, else ROUTE.
- IDLE, accepted beat, dest invalid:
  - Beat discarded; decode_err=1 next cycle; drop_count += 1, saturating at all-ones.
  - Next state IDLE if s_tlast, else DROP.
- ROUTE, accepted beat: load output register with route_sel; s_tdest ignored; s_tlast -> IDLE.
- DROP, accepted beat: discarded; s_tlast -> IDLE; no further decode_err or count.
- Drain without a new load: out_valid <= 0. Load and drain in the same cycle: register reloads, giving back-to-back throughput of 1 beat/cycle.
- Latency: an accepted beat appears on m_* the following cycle.
- Held beat: data, sel and last stay stable while m_tvalid=1 and the selected m_tready=0 (AXI rule).
- New packet to a different master may be accepted in the cycle the previous last beat drains. The one-hot select switches with no idle cycle and no overlap of m_tvalid bits.
- Ready on unselected masters is ignored.

Test Plan:
- Single-beat packets, dest 0,1,2,3, data 0xA0..0xA3, all m_tready=1 -> m_tvalid = 0001, 0010, 0100, 1000 on consecutive cycles, 1 cycle after each accept, with m_tdata matching and m_tlast=1.
- 4-beat packet to dest 2 with s_tdest changed to 1 on beats 2-4 -> all beats exit on m_tvalid=0100. Then a 1-beat packet to dest 1 follows back-to-back with no bubble.
- Backpressure: m_tready[3]=0 for 5 cycles during a 3-beat packet to dest 3 -> s_tready=0 while the register is full, m_tdata stable, no beat lost or duplicated. Release drains 1 beat/cycle.
- NUM_MASTERS=3, dest=3, 2-beat packet -> s_tready=1 both beats, m_tvalid stays 0, decode_err pulses once, drop_count 0->1. A following packet to dest 0 routes normally.
- Assert reset after beat 2 of a 4-beat packet to dest 1 -> outputs clear immediately. After release, a beat with dest 2 is decoded as a first beat, giving m_tvalid=0100.
- CNT_WIDTH=2, 5 invalid-dest packets -> drop_count 1,2,3,3,3.
